// File: rtl/alu_pipe_if.sv
// alu_pipe_if
// Purpose: bundles the issue-side and writeback-side handshakes of the
//   pipelined ALU so the producer and consumer connect with one port.
// Signals:
//   in_valid/in_ready          issue handshake, transfer when both high
//   operand1/operand2/op       operands and opcode presented with in_valid
//   out_valid/out_ready        result handshake, transfer when both high
//   result                     registered ALU result
//   zero/neg/carry/ovf_flag    NZCV flag set belonging to result
//   illegal_op                 opcode was unimplemented, result forced to 0
// Modports: master = decode/writeback side, slave = ALU side.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             neg_flag;
  logic             carry_flag;
  logic             ovf_flag;
  logic             illegal_op;

  modport master (
    output in_valid, operand1, operand2, op, out_ready,
    input  in_ready, out_valid, result, zero_flag, neg_flag, carry_flag,
           ovf_flag, illegal_op
  );

  modport slave (
    input  in_valid, operand1, operand2, op, out_ready,
    output in_ready, out_valid, result, zero_flag, neg_flag, carry_flag,
           ovf_flag, illegal_op
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe
// Purpose: registered ALU with valid/ready handshakes on both sides, a
//   one-entry output buffer, NZCV flags, a WIDTH-cycle shift-add multiplier
//   and illegal-opcode reporting.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  alu_pipe_if.slave: issue handshake + operands/op in,
//        result handshake + result/flags/illegal_op out
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;

  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  logic [0:0]       state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, neg_q, carry_q, ovf_q, illegal_q;

  logic [WIDTH-1:0] a, b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;
  logic [WIDTH-1:0] mul_step;
  logic             accept, mul_done, load_single;
  logic [WIDTH-1:0] nxt_res;

  assign a     = bus.operand1;
  assign b     = bus.operand2;
  assign shamt = b[SHW-1:0];

  // Extra top bit captures the carry-out for ADD and the borrow for SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Issue is allowed only when idle and the output slot is empty or draining.
  assign bus.in_ready = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign load_single  = accept && (bus.op != OP_MUL);
  assign mul_done     = (state == MUL) && (cnt == LAST_STEP);

  // One shift-add iteration; on the last step this is the final product.
  assign mul_step = mplier[0] ? (acc + mcand) : acc;

  // Single-cycle datapath. ADD/SUB are the only ops producing carry/overflow.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = ~diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: alu_res = a << shamt;
      OP_SRL: alu_res = a >> shamt;
      OP_SRA: alu_res = $unsigned($signed(a) >>> shamt);
      OP_MUL: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  assign nxt_res = mul_done ? mul_step : alu_res;

  // Control state and multiplier datapath. The multiplicand shifts left and
  // the multiplier shifts right so bit 0 always selects the next partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (bus.op == OP_MUL)) begin
            state  <= MUL;
            cnt    <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
          end
        end
        default: begin
          acc    <= mul_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (mul_done) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  // One-entry output buffer. A new load wins over a drain at the same edge,
  // so out_valid stays high; otherwise a drain empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (load_single || mul_done) begin
      out_valid_q <= 1'b1;
      result_q    <= nxt_res;
      zero_q      <= (nxt_res == '0);
      neg_q       <= nxt_res[WIDTH-1];
      carry_q     <= alu_c && !mul_done;
      ovf_q       <= alu_v && !mul_done;
      illegal_q   <= alu_ill && !mul_done;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.zero_flag  = zero_q;
  assign bus.neg_flag   = neg_q;
  assign bus.carry_flag = carry_q;
  assign bus.ovf_flag   = ovf_q;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe
// Purpose: directed self-checking bench for alu_pipe (WIDTH=32). Drives the
//   interface one step at a time and compares outputs against hand-computed
//   values. Flags are compared packed as {zero, neg, carry, ovf}.
module tb_alu_pipe;
  localparam int WIDTH = 32;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_BAD = 4'b1100;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   wait_cycles;
  logic [3:0] flags;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(WIDTH)) bus ();

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign flags = {bus.zero_flag, bus.neg_flag, bus.carry_flag, bus.ovf_flag};

  // Advance one edge and settle just after it, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an operation and hold it until the edge where it is accepted.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    bit done;
    done = 1'b0;
    bus.op       = op;
    bus.operand1 = x;
    bus.operand2 = y;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      done = (bus.in_ready === 1'b1);
      tick();
    end
    bus.in_valid = 1'b0;
    checkOutput("accepted", 32'(done), 32'd1);
  endtask

  // Count edges until out_valid rises, bounded.
  task automatic waitOutValid(output int cycles);
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.op       = 4'b0;
    bus.operand1 = '0;
    bus.operand2 = '0;
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_result", bus.result, 32'h0);
    checkOutput("rst_flags", 32'(flags), 32'h0);
    checkOutput("rst_illegal", 32'(bus.illegal_op), 32'd0);
    rst = 1'b0;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

    $display("[TB] add/sub");
    applyStimulus(OP_ADD, 32'h8, 32'h8);
    checkOutput("add_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("add_result", bus.result, 32'h10);
    checkOutput("add_flags", 32'(flags), 32'h0);

    applyStimulus(OP_SUB, 32'h8, 32'h8);
    checkOutput("sub_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("sub_result", bus.result, 32'h0);
    checkOutput("sub_flags", 32'(flags), 32'b1010);

    applyStimulus(OP_SUB, 32'h3, 32'h5);
    checkOutput("sub_borrow_result", bus.result, 32'hFFFF_FFFE);
    checkOutput("sub_borrow_flags", 32'(flags), 32'b0100);

    applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    checkOutput("add_ovf_result", bus.result, 32'h8000_0000);
    checkOutput("add_ovf_flags", 32'(flags), 32'b0101);

    applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    checkOutput("add_carry_result", bus.result, 32'h0);
    checkOutput("add_carry_flags", 32'(flags), 32'b1010);

    $display("[TB] multiply latency");
    applyStimulus(OP_MUL, 32'h1_0000, 32'h1_0000);
    checkOutput("mul_busy_0", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      checkOutput("mul_busy", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
    end
    tick();
    checkOutput("mul_done_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("mul_wrap_result", bus.result, 32'h0);
    checkOutput("mul_wrap_flags", 32'(flags), 32'b1000);

    applyStimulus(OP_MUL, 32'd1234, 32'd5678);
    waitOutValid(wait_cycles);
    checkOutput("mul_latency", 32'(wait_cycles), 32'd32);
    checkOutput("mul_result", bus.result, 32'd7006652);
    checkOutput("mul_flags", 32'(flags), 32'b0000);

    $display("[TB] back-pressure");
    tick();
    checkOutput("drain_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    applyStimulus(OP_ADD, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold_result", bus.result, 32'd7);
      checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    applyStimulus(OP_XOR, 32'hF0, 32'hFF);
    checkOutput("xor_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("xor_result", bus.result, 32'h0F);
    tick();
    checkOutput("xor_drained", 32'(bus.out_valid), 32'd0);

    $display("[TB] shifts and compare");
    applyStimulus(OP_SRA, 32'h8000_0000, 32'h21);
    checkOutput("sra_result", bus.result, 32'hC000_0000);
    checkOutput("sra_flags", 32'(flags), 32'b0100);
    applyStimulus(OP_SRL, 32'h8000_0000, 32'hFFFF_FF24);
    checkOutput("srl_result", bus.result, 32'h0800_0000);
    applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'h1);
    checkOutput("slt_result", bus.result, 32'h1);
    applyStimulus(OP_SLT, 32'h1, 32'hFFFF_FFFF);
    checkOutput("slt_false", bus.result, 32'h0);

    $display("[TB] illegal opcode");
    applyStimulus(OP_BAD, 32'h1234, 32'h5678);
    checkOutput("ill_flag", 32'(bus.illegal_op), 32'd1);
    checkOutput("ill_result", bus.result, 32'h0);
    checkOutput("ill_flags", 32'(flags), 32'b1000);

    $display("[TB] reset during multiply");
    applyStimulus(OP_MUL, 32'd9, 32'd9);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("mrst_illegal", 32'(bus.illegal_op), 32'd0);
    for (int i = 0; i < 30; i++) begin
      tick();
      checkOutput("mrst_no_pulse", 32'(bus.out_valid), 32'd0);
    end
    applyStimulus(OP_ADD, 32'd2, 32'd2);
    checkOutput("post_add_result", bus.result, 32'd4);
    checkOutput("post_add_illegal", 32'(bus.illegal_op), 32'd0);
    checkOutput("post_add_valid", 32'(bus.out_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
